// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, immediate extension, 32x32 register file
// with writeback bypass, and the ID/EX pipeline register.
module decode_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCNextD,
  input  logic        FlushE,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ResultW,
  output logic        RegWriteE,
  output logic        ResultSrcE,
  output logic        MemWriteE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1_E,
  output logic [31:0] RD2_E,
  output logic [31:0] Imm_Ext_E,
  output logic [4:0]  RS1_E,
  output logic [4:0]  RS2_E,
  output logic [4:0]  RD_E,
  output logic [31:0] PCE,
  output logic [31:0] PCNextE
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;

  logic        reg_write_d;
  logic        result_src_d;
  logic        mem_write_d;
  logic        branch_d;
  logic        alu_src_d;
  logic [2:0]  alu_control_d;
  logic [31:0] imm_ext_d;
  logic [31:0] rd1_d;
  logic [31:0] rd2_d;

  logic [31:0] regs [32];

  assign opcode    = InstrD[6:0];
  assign funct3    = InstrD[14:12];
  assign funct7_b5 = InstrD[30];
  assign rs1       = InstrD[19:15];
  assign rs2       = InstrD[24:20];
  assign rd        = InstrD[11:7];

  // Shared funct3 -> ALU op mapping; R-type alone may turn 000 into sub.
  function automatic logic [2:0] alu_from_funct3(input logic [2:0] f3, input logic allow_sub,
                                                 input logic sub_bit);
    logic [2:0] op;
    op = ALU_ADD;
    unique case (f3)
      3'b000:  op = (allow_sub && sub_bit) ? ALU_SUB : ALU_ADD;
      3'b111:  op = ALU_AND;
      3'b110:  op = ALU_OR;
      3'b010:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  always_comb begin
    reg_write_d   = 1'b0;
    result_src_d  = 1'b0;
    mem_write_d   = 1'b0;
    branch_d      = 1'b0;
    alu_src_d     = 1'b0;
    alu_control_d = ALU_ADD;
    imm_ext_d     = '0;
    unique case (opcode)
      OP_R: begin
        reg_write_d   = 1'b1;
        alu_control_d = alu_from_funct3(funct3, 1'b1, funct7_b5);
      end
      OP_I: begin
        reg_write_d   = 1'b1;
        alu_src_d     = 1'b1;
        alu_control_d = alu_from_funct3(funct3, 1'b0, funct7_b5);
        imm_ext_d     = {{20{InstrD[31]}}, InstrD[31:20]};
      end
      OP_LOAD: begin
        reg_write_d  = 1'b1;
        result_src_d = 1'b1;
        alu_src_d    = 1'b1;
        imm_ext_d    = {{20{InstrD[31]}}, InstrD[31:20]};
      end
      OP_STORE: begin
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_ext_d   = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      end
      OP_BRANCH: begin
        branch_d      = 1'b1;
        alu_control_d = ALU_SUB;
        imm_ext_d     = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (RegWriteW && (RDW != 5'd0)) begin
      regs[RDW] <= ResultW;
    end
  end

  // Writeback data is forwarded so an instruction decoding alongside the write sees it.
  always_comb begin
    rd1_d = regs[rs1];
    rd2_d = regs[rs2];
    if (RegWriteW && (RDW != 5'd0) && (RDW == rs1)) rd1_d = ResultW;
    if (RegWriteW && (RDW != 5'd0) && (RDW == rs2)) rd2_d = ResultW;
    if (rs1 == 5'd0) rd1_d = '0;
    if (rs2 == 5'd0) rd2_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteE   <= 1'b0;
      ResultSrcE  <= 1'b0;
      MemWriteE   <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ALUControlE <= '0;
      RD1_E       <= '0;
      RD2_E       <= '0;
      Imm_Ext_E   <= '0;
      RS1_E       <= '0;
      RS2_E       <= '0;
      RD_E        <= '0;
      PCE         <= '0;
      PCNextE     <= '0;
    end else begin
      // A flush only squashes control; operands and indices still flow for hazard logic.
      RegWriteE   <= FlushE ? 1'b0 : reg_write_d;
      ResultSrcE  <= FlushE ? 1'b0 : result_src_d;
      MemWriteE   <= FlushE ? 1'b0 : mem_write_d;
      BranchE     <= FlushE ? 1'b0 : branch_d;
      ALUSrcE     <= FlushE ? 1'b0 : alu_src_d;
      ALUControlE <= FlushE ? 3'b000 : alu_control_d;
      RD1_E       <= rd1_d;
      RD2_E       <= rd2_d;
      Imm_Ext_E   <= imm_ext_d;
      RS1_E       <= rs1;
      RS2_E       <= rs2;
      RD_E        <= rd;
      PCE         <= PCD;
      PCNextE     <= PCNextD;
    end
  end

endmodule

// File: doc/decode_cycle.md
# decode_cycle

Second stage of the five-stage RV32I pipeline. Consumes the IF/ID outputs of the fetch stage (InstrD, PCD, PCNextD), decodes the instruction, and reads the 32x32 register file. It also sign-extends the immediate and registers everything into the ID/EX pipeline register for the execute stage. It owns the register file, whose write port is driven from writeback.

## Interface

- No parameters; XLEN fixed at 32, register count fixed at 32.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- InstrD  in  32  instruction from fetch stage.
- PCD  in  32  PC of InstrD.
- PCNextD  in  32  PC+4 of InstrD.
- FlushE  in  1  turn the next ID/EX load into a bubble.
- RegWriteW  in  1  writeback register-file write enable.
- RDW  in  5  writeback destination register.
- ResultW  in  32  writeback data.
- RegWriteE  out  1  registered write enable.
- ResultSrcE  out  1  0 = ALU result, 1 = load data.
- MemWriteE  out  1  store.
- BranchE  out  1  beq.
- ALUSrcE  out  1  0 = RD2, 1 = immediate.
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- RD1_E, RD2_E  out  32  source operand values.
- Imm_Ext_E  out  32  sign-extended immediate.
- RS1_E, RS2_E, RD_E  out  5  register indices (for hazard/forwarding).
- PCE, PCNextE  out  32  forwarded PC values.

## Operation

- Supported opcodes:
  - 0110011 R-type: add/sub/and/or/slt.
  - 0010011 I-ALU: addi/andi/ori/slti.
  - 0000011 lw.
  - 0100011 sw.
  - 1100011 beq.
- Any other opcode decodes to all control outputs 0 (no write, no store, no branch).
- R-type ALUControl:
  - funct3 000 with funct7[5]=1 → sub; funct3 000 otherwise → add.
  - funct3 111 → and, 110 → or, 010 → slt.
- I-ALU ALUControl: same funct3 mapping, always add for 000 (funct7 ignored).
- lw/sw → add; beq → sub.
- Other funct3 values under a valid opcode → add.
- Immediate formats, bit 31 sign-extended:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - R-type: 0.
- Register file:
  - Combinational read of rs1 = instr[19:15] and rs2 = instr[24:20].
  - x0 always reads 0; writes to x0 are ignored.
  - Write on rising clk when RegWriteW=1 and RDW≠0.
  - Internal bypass: when RegWriteW=1, RDW≠0 and RDW equals a read index, that read returns ResultW in the same cycle.
- ID/EX register:
  - Loads all outputs every rising edge.
  - If FlushE=1, all control outputs load 0; data, index and PC fields load normally.

## Timing

- Latency is one cycle: InstrD/PCD/PCNextD stable before edge n appear on the *E outputs after edge n.
- Register-file write issued at edge n is visible to a read in the cycle before edge n (via bypass) and in all later cycles.
- Reset (rst=0), asynchronously and regardless of clk:
  - All ID/EX outputs go to 0.
  - All 32 registers clear to 0.
  - Held while rst=0. First load on the first rising edge with rst=1.
- Reset asserted mid-operation: any in-flight instruction is discarded and no pending writeback is committed.
- FlushE and RegWriteW asserted together: the write still commits; only ID/EX control outputs are zeroed.

## Test plan

- **Reset.** rst=0 with random inputs.
  - All outputs read 0.
  - After release, InstrD=0x00000013 (nop) gives RegWriteE=1, RD_E=0, Imm_Ext_E=0.
- **I-type decode.** InstrD=0x00500093 (addi x1,x0,5):
  - RegWriteE=1, ALUSrcE=1, ALUControlE=000.
  - Imm_Ext_E=5, RD_E=1, RD1_E=0.
- **Write then R-type read.**
  - Setup: write x1=5 and x2=7 via the W port.
  - Stimulus: InstrD=0x002081B3 (add x3,x1,x2).
  - Required: RD1_E=5, RD2_E=7, RD_E=3, ALUSrcE=0.
  - Variant: with funct7 bit 30 set (0x402081B3), ALUControlE=001.
- **Bypass.** In the same cycle as RegWriteW=1, RDW=2, ResultW=0xDEADBEEF, present InstrD=0x0020A423 (sw x2,8(x1)):
  - RD2_E=0xDEADBEEF.
  - MemWriteE=1, RegWriteE=0, Imm_Ext_E=8.
- **Branch.** InstrD=0xFE208EE3 (beq x1,x2,-4) with PCD=0x100:
  - BranchE=1, ALUControlE=001.
  - Imm_Ext_E=0xFFFFFFFC, PCE=0x100.
- **x0, flush and illegal opcode.**
  - RegWriteW=1, RDW=0, ResultW=9: a later read of x0 returns 0.
  - FlushE=1 with a valid add: all control outputs are 0 and RD_E is still loaded.
  - Opcode 0x7F: all control outputs are 0.
